// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control FSM.
package mcc_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_ILLEGAL = 3'd6
   } state_t;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/mcc_perf_counters.sv
// Purpose: active-cycle and retired-instruction counters for the multi-cycle controller.
// Latency: counts visible the cycle after the qualifying edge.
// Backpressure: none; counters wrap modulo 2^32.
module mcc_perf_counters (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        active,
   input  logic        retire,
   output logic [31:0] cycle_count,
   output logic [31:0] instret
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count <= 32'd0;
         instret     <= 32'd0;
      end else begin
         if (active) cycle_count <= cycle_count + 32'd1;
         if (retire) instret     <= instret + 32'd1;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multi-cycle control FSM for R-type/ld/sd/beq; MCC_PERF_EN adds perf counters.
// Latency: R 4, ld 5, sd 4, beq 3 cycles, plus one per mem_ready wait cycle.
// Backpressure: mem_req/mem_we held stable in FETCH/MEM until mem_ready.
module multicycle_controller
   import mcc_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic [2:0]  state,
`ifdef MCC_PERF_EN
   output logic [31:0] cycle_count,
   output logic [31:0] instret,
`endif
   output logic        illegal
);

   state_t cur_state, nxt_state;
   state_t boundary;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cur_state <= S_IDLE;
      else          cur_state <= nxt_state;
   end

   // Instruction boundary: run is only honoured here
   assign boundary = run ? S_FETCH : S_IDLE;

   always_comb begin
      nxt_state  = cur_state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sel    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      unique case (cur_state)
         S_IDLE: begin
            if (run) nxt_state = S_FETCH;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               nxt_state = S_DECODE;
            end
         end
         S_DECODE: begin
            nxt_state = is_legal(opcode) ? S_EXEC : S_ILLEGAL;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            case (opcode)
               OP_RTYPE: begin
                  alu_op    = ALU_FUNCT;
                  nxt_state = S_WB;
               end
               OP_LD, OP_SD: begin
                  alu_src_b = SRCB_IMM;
                  nxt_state = S_MEM;
               end
               OP_BEQ: begin
                  alu_op    = ALU_SUB;
                  pc_src    = 1'b1;
                  pc_write  = alu_zero;
                  nxt_state = boundary;
               end
               default: nxt_state = S_ILLEGAL;
            endcase
         end
         S_MEM: begin
            // ALU keeps computing rs1+imm so the address stays valid while waiting
            mem_req   = 1'b1;
            mem_sel   = 1'b1;
            mem_we    = (opcode == OP_SD);
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            if (mem_ready) nxt_state = (opcode == OP_LD) ? S_WB : boundary;
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode == OP_LD);
            nxt_state  = boundary;
         end
         S_ILLEGAL: nxt_state = S_ILLEGAL;
         default:   nxt_state = S_IDLE;
      endcase
   end

   assign state   = cur_state;
   // ILLEGAL is only left through reset, so the state itself is the sticky flag
   assign illegal = (cur_state == S_ILLEGAL);

`ifdef MCC_PERF_EN
   logic active, retire;

   assign active = (cur_state != S_IDLE) && (cur_state != S_ILLEGAL);
   assign retire = (cur_state == S_WB)
                || (cur_state == S_EXEC && opcode == OP_BEQ)
                || (cur_state == S_MEM  && opcode == OP_SD && mem_ready);

   mcc_perf_counters u_perf (
      .clk         (clk),
      .reset_n     (reset_n),
      .active      (active),
      .retire      (retire),
      .cycle_count (cycle_count),
      .instret     (instret)
   );
`endif

endmodule
